// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: RV32 width codes,
// FSM state encoding and the funct3 legality helper.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_WR_ISSUE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_WR_WAIT  = 3'd5
  } lsu_state_e;

  // Unsigned widths only make sense for loads; 011/110/111 are never legal.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    logic bad;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = is_store;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Byte-lane steering between the 32-bit memory word and the CPU:
// extracts/extends load values and merges sub-word store data into a read word.
module dmem_lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] mem_word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_val_o,
  output logic [31:0] merged_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Select the addressed byte and half-word (little-endian lanes).
  always_comb begin
    case (off_i)
      2'd0:    lane_b = mem_word_i[7:0];
      2'd1:    lane_b = mem_word_i[15:8];
      2'd2:    lane_b = mem_word_i[23:16];
      default: lane_b = mem_word_i[31:24];
    endcase
    lane_h = off_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];
  end

  // Sign- or zero-extend the selected lane according to the load width.
  always_comb begin
    case (funct3_i)
      F3_B:    load_val_o = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_val_o = {24'd0, lane_b};
      F3_H:    load_val_o = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_val_o = {16'd0, lane_h};
      default: load_val_o = mem_word_i;
    endcase
  end

  // Overlay store data onto the read word; full-word stores pass wdata unchanged.
  always_comb begin
    merged_o = mem_word_i;
    case (funct3_i)
      F3_B: begin
        case (off_i)
          2'd0:    merged_o[7:0]   = wdata_i[7:0];
          2'd1:    merged_o[15:8]  = wdata_i[7:0];
          2'd2:    merged_o[23:16] = wdata_i[7:0];
          default: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      F3_H: begin
        if (off_i[1]) merged_o[31:16] = wdata_i[15:0];
        else          merged_o[15:0]  = wdata_i[15:0];
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving data_mem's re/we strobe protocol. Sub-word stores
// are performed as read-modify-write because data_mem has no byte enables.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDRW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        mem_re_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_din_o,
  input  logic [31:0] mem_dout_i,
  input  logic        mem_valid_i
);

  lsu_state_e  state_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_din_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        err_q;

  logic        req_bad;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Classify the incoming request: bad width code, misalignment or out-of-range address.
  always_comb begin
    req_bad = f3_illegal(is_store_i, funct3_i)
            | (((funct3_i == F3_H) || (funct3_i == F3_HU)) && addr_i[0])
            | ((funct3_i == F3_W) && (addr_i[1:0] != 2'b00))
            | ((addr_i >> ADDRW) != 32'd0);
  end

  dmem_lsu_align u_align (
    .mem_word_i (mem_dout_i),
    .off_i      (off_q),
    .funct3_i   (funct3_q),
    .wdata_i    (wdata_q),
    .load_val_o (load_val),
    .merged_o   (merged)
  );

  // Transaction sequencer with registered completion/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      off_q      <= 2'd0;
      wdata_q    <= 32'd0;
      mem_addr_q <= 32'd0;
      mem_din_q  <= 32'd0;
      rdata_q    <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            is_store_q <= is_store_i;
            funct3_q   <= funct3_i;
            off_q      <= addr_i[1:0];
            wdata_q    <= wdata_i;
            if (req_bad) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              mem_addr_q <= {addr_i[31:2], 2'b00};
              mem_din_q  <= wdata_i;
              if (is_store_i && (funct3_i == F3_W)) state_q <= S_WR_ISSUE;
              else                                  state_q <= S_RD_ISSUE;
            end
          end
        end
        S_RD_ISSUE: state_q <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (mem_valid_i) begin
            if (is_store_q) begin
              mem_din_q <= merged;
              state_q   <= S_WR_ISSUE;
            end else begin
              rdata_q <= load_val;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        S_WR_ISSUE: state_q <= S_WR_HOLD;
        // A third write-enable cycle would start a second write in data_mem.
        S_WR_HOLD:  state_q <= S_WR_WAIT;
        S_WR_WAIT: begin
          if (mem_valid_i) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Memory strobes are decoded directly from the state register.
  always_comb begin
    mem_re_o = (state_q == S_RD_ISSUE);
    mem_we_o = (state_q == S_WR_ISSUE) || (state_q == S_WR_HOLD);
    busy_o   = (state_q != S_IDLE);
  end

  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rdata_o    = rdata_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_din_o  = mem_din_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu paired with a behavioural data_mem model; expected
// results are queued at issue time and checked when done appears.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        is_store_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic        busy_o, done_o, err_o, mem_re_o, mem_we_o;
  logic [31:0] rdata_o, mem_addr_o, mem_din_o;
  logic [31:0] mem_dout_i = 32'd0;
  logic        mem_valid_i = 1'b0;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDRW(8)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .is_store_i(is_store_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_din_o(mem_din_o), .mem_dout_i(mem_dout_i), .mem_valid_i(mem_valid_i)
  );

  // data_mem model: strobe seen -> one enable cycle (access) -> valid for one cycle.
  logic [31:0] mem [0:63];
  logic        mstage = 1'b0;
  logic        mwr = 1'b0;
  always @(posedge clk) begin
    mem_valid_i <= 1'b0;
    if (!mstage && (mem_re_o || mem_we_o)) begin
      mstage <= 1'b1;
      mwr    <= mem_we_o;
    end else if (mstage) begin
      if (mwr) mem[mem_addr_o[7:2]] <= mem_din_o;
      else     mem_dout_i <= mem[mem_addr_o[7:2]];
      mem_valid_i <= 1'b1;
      mstage      <= 1'b0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int re_cnt   = 0;
  int we_cnt   = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_re_o) re_cnt++;
    if (mem_we_o) we_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    bit          chk_rd;
    bit          err;
    int          lat;
    int          req_cyc;
  } sb_t;
  sb_t sb[$];

  // Completion monitor: pop the oldest expectation on each done pulse.
  always @(negedge clk) begin
    if (done_o) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", {31'd0, done_o}, 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        $display("txn %s rdata=0x%08h err=%0d lat=%0d", e.tag, rdata_o, err_o, cyc - e.req_cyc);
        check_eq({e.tag, "_err"}, {31'd0, err_o}, {31'd0, e.err});
        check_eq({e.tag, "_lat"}, cyc - e.req_cyc, e.lat);
        if (e.chk_rd) check_eq({e.tag, "_rdata"}, rdata_o, e.rdata);
      end
    end
  end

  // Called at posedge+2; drives req for one cycle, returns at the next posedge+2.
  task automatic issue(input string tag, input bit st, input bit [2:0] f3,
                       input bit [31:0] a, input bit [31:0] wd,
                       input bit [31:0] exp_rd, input bit chk_rd,
                       input bit exp_err, input int lat, input bit push);
    sb_t e;
    is_store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd; req_i = 1'b1;
    if (push) begin
      e.tag = tag; e.rdata = exp_rd; e.chk_rd = chk_rd; e.err = exp_err;
      e.lat = lat; e.req_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #2;
    req_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #2;
    end
    if (sb.size() != 0) begin
      check_eq("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(posedge clk); #2;
  endtask

  int re0, we0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    check_eq("rst_strobes", {30'd0, mem_re_o, mem_we_o}, 32'd0);
    check_eq("rst_rdata", rdata_o, 32'd0);
    check_eq("rst_addr", mem_addr_o, 32'd0);
    rst = 1'b0;
    @(posedge clk); #2;

    // SW then LW round trip
    we0 = we_cnt;
    issue("sw10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 0, 4, 1);
    drain();
    check_eq("sw_we_cycles", we_cnt - we0, 32'd2);
    issue("lw10", 0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 1, 0, 4, 1);
    drain();

    // Sub-word loads
    mem[8] = 32'h80FF7F01;
    issue("lb23",  0, 3'b000, 32'h23, 0, 32'hFFFFFF80, 1, 0, 4, 1); drain();
    issue("lbu23", 0, 3'b100, 32'h23, 0, 32'h00000080, 1, 0, 4, 1); drain();
    issue("lh22",  0, 3'b001, 32'h22, 0, 32'hFFFF80FF, 1, 0, 4, 1); drain();
    issue("lhu20", 0, 3'b101, 32'h20, 0, 32'h00007F01, 1, 0, 4, 1); drain();
    issue("lb20",  0, 3'b000, 32'h20, 0, 32'h00000001, 1, 0, 4, 1); drain();

    // Read-modify-write stores
    mem[8] = 32'h11223344;
    issue("sb21", 1, 3'b000, 32'h21, 32'h000000AB, 0, 0, 0, 7, 1); drain();
    check_eq("sb21_mem", mem[8], 32'h1122AB44);
    issue("sh22", 1, 3'b001, 32'h22, 32'h0000BEEF, 0, 0, 0, 7, 1); drain();
    check_eq("sh22_mem", mem[8], 32'hBEEFAB44);
    issue("lw20", 0, 3'b010, 32'h20, 0, 32'hBEEFAB44, 1, 0, 4, 1); drain();

    // Error cases: one-cycle done with err, no memory strobes
    re0 = re_cnt; we0 = we_cnt;
    issue("e_lw02",  0, 3'b010, 32'h02,  0, 0, 0, 1, 1, 1); drain();
    issue("e_sh05",  1, 3'b001, 32'h05,  0, 0, 0, 1, 1, 1); drain();
    issue("e_lw100", 0, 3'b010, 32'h100, 0, 0, 0, 1, 1, 1); drain();
    issue("e_f3011", 0, 3'b011, 32'h00,  0, 0, 0, 1, 1, 1); drain();
    issue("e_sbu",   1, 3'b100, 32'h00,  0, 0, 0, 1, 1, 1); drain();
    check_eq("err_no_strobes", (re_cnt - re0) + (we_cnt - we0), 32'd0);

    // Back-to-back: second req on done cycle
    issue("b2b_a", 0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 1, 0, 4, 1);
    for (int i = 0; i < 20; i++) begin
      if (done_o) break;
      @(posedge clk); #2;
    end
    issue("b2b_b", 0, 3'b001, 32'h22, 0, 32'hFFFFBEEF, 1, 0, 4, 1);
    drain();

    // req during busy is ignored
    re0 = re_cnt; we0 = we_cnt;
    issue("busy_lw", 0, 3'b010, 32'h20, 0, 32'hBEEFAB44, 1, 0, 4, 1);
    is_store_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h40; wdata_i = 32'h12345678; req_i = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    req_i = 1'b0;
    drain();
    check_eq("busy_re_cnt", re_cnt - re0, 32'd1);
    check_eq("busy_we_cnt", we_cnt - we0, 32'd0);
    check_eq("busy_mem40", mem[16], 32'd0);

    // Asynchronous reset in RD_WAIT aborts without done
    issue("rst_lw", 0, 3'b010, 32'h10, 0, 0, 0, 0, 4, 0);
    @(posedge clk); #2;
    check_eq("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("arst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("arst_rdata", rdata_o, 32'd0);
    check_eq("arst_strobes", {30'd0, mem_re_o, mem_we_o}, 32'd0);
    check_eq("arst_addr", mem_addr_o, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    issue("post_rst_lw", 0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 1, 0, 4, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
